// File: rtl/i2c_target_if.sv
// I2C pad-side bus bundle: SCL and SDA from the pads, and the open-drain SDA pull-down enable.
interface i2c_target_if;
    logic scl;
    logic sda_in;
    logic sda_oe;

    modport master (output scl, output sda_in, input sda_oe);
    modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_target.sv
// I2C target with a small register file: pointer write, data write and sequential read with wrap.
// Optional 3-sample majority glitch filter on SCL/SDA when I2C_TARGET_GLITCH_FILTER_EN is defined.
//
// state     | meaning
// IDLE      | waiting for START
// ADDR      | shifting in device address + R/W
// ADDR_ACK  | acknowledging a matched address
// PTR       | shifting in register pointer
// PTR_ACK   | acknowledging pointer
// WDATA     | shifting in a write data byte
// WDATA_ACK | acknowledging a write byte, then pointer advances
// RDATA     | shifting out reg[ptr]
// RDATA_ACK | sampling master ACK/NACK
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NREG     = 4
) (
    input  logic                clk,
    input  logic                res_n,
    i2c_target_if.slave         bus,
    output logic [8*NREG-1:0]   regs_out,
    output logic                wr_strobe,
    output logic [3:0]          wr_index,
    output logic                busy
);
    localparam int PW = $clog2(NREG);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] ADDR      = 4'd1;
    localparam logic [3:0] ADDR_ACK  = 4'd2;
    localparam logic [3:0] PTR       = 4'd3;
    localparam logic [3:0] PTR_ACK   = 4'd4;
    localparam logic [3:0] WDATA     = 4'd5;
    localparam logic [3:0] WDATA_ACK = 4'd6;
    localparam logic [3:0] RDATA     = 4'd7;
    localparam logic [3:0] RDATA_ACK = 4'd8;

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_f, sda_f;
    logic          scl_q, sda_q;
    logic          scl_rise, scl_fall, start_cond, stop_cond;
    logic [3:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg, tx, rx_byte;
    logic [PW-1:0] ptr;
    logic          rw, ack_hold, oe_q, rx_state, last_bit;
    logic [7:0]    regs [NREG];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl};
            sda_sync <= {sda_sync[0], bus.sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    // registered majority of the current and two previous samples
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_f    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                        (scl_hist[0] & scl_hist[1]);
            sda_f    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                        (sda_hist[0] & sda_hist[1]);
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise   = scl_f & ~scl_q;
    assign scl_fall   = ~scl_f & scl_q;
    assign start_cond = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_cond  = scl_f & scl_q & ~sda_q & sda_f;
    assign rx_byte    = {shreg[6:0], sda_f};
    assign rx_state   = (state == ADDR) || (state == PTR) || (state == WDATA);
    assign last_bit   = scl_rise && (bit_cnt == 4'd7);
    assign bus.sda_oe = oe_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            tx        <= 8'h00;
            ptr       <= '0;
            rw        <= 1'b0;
            ack_hold  <= 1'b0;
            oe_q      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= 4'd0;
            busy      <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_cond) begin
                state    <= IDLE;
                oe_q     <= 1'b0;
                busy     <= 1'b0;
                ack_hold <= 1'b0;
            end else if (start_cond) begin
                state    <= ADDR;
                bit_cnt  <= 4'd0;
                oe_q     <= 1'b0;
                ack_hold <= 1'b0;
            end else begin
                if (scl_rise && rx_state) begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    IDLE: ;
                    ADDR: if (last_bit) begin
                        ack_hold <= 1'b0;
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            state <= ADDR_ACK;
                            rw    <= rx_byte[0];
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    PTR: if (last_bit) begin
                        ptr      <= rx_byte[PW-1:0];
                        ack_hold <= 1'b0;
                        state    <= PTR_ACK;
                    end
                    WDATA: if (last_bit) begin
                        regs[ptr] <= rx_byte;
                        wr_strobe <= 1'b1;
                        wr_index  <= 4'(ptr);
                        ack_hold  <= 1'b0;
                        state     <= WDATA_ACK;
                    end
                    // first SCL fall pulls SDA low, second fall ends the ACK clock
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!ack_hold) begin
                            ack_hold <= 1'b1;
                            oe_q     <= 1'b1;
                        end else begin
                            ack_hold <= 1'b0;
                            bit_cnt  <= 4'd0;
                            oe_q     <= 1'b0;
                            if (state == ADDR_ACK) begin
                                if (rw) begin
                                    state <= RDATA;
                                    tx    <= regs[ptr];
                                    oe_q  <= ~regs[ptr][7];
                                end else begin
                                    state <= PTR;
                                end
                            end else if (state == PTR_ACK) begin
                                state <= WDATA;
                            end else begin
                                ptr   <= ptr + PW'(1);
                                state <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                oe_q     <= 1'b0;
                                ack_hold <= 1'b0;
                                state    <= RDATA_ACK;
                            end else begin
                                tx   <= {tx[6:0], 1'b0};
                                oe_q <= ~tx[6];
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state <= IDLE;
                            end else begin
                                ptr      <= ptr + PW'(1);
                                ack_hold <= 1'b1;
                            end
                        end else if (scl_fall && ack_hold) begin
                            ack_hold <= 1'b0;
                            bit_cnt  <= 4'd0;
                            tx       <= regs[ptr];
                            oe_q     <= ~regs[ptr][7];
                            state    <= RDATA;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NREG; i++) regs_out[8*i +: 8] = regs[i];
    end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, array-based register model, randomized write/read traffic.
module tb_i2c_target;
    localparam int         NREG = 4;
    localparam logic [6:0] DEV  = 7'h42;
    localparam int         Q    = 8;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int EXP_GLITCH_STARTS = 0;
`else
    localparam int EXP_GLITCH_STARTS = 1;
`endif

    logic              clk = 1'b0;
    logic              res_n;
    logic              m_sda;
    logic              line;
    logic [8*NREG-1:0] regs_out;
    logic              wr_strobe;
    logic [3:0]        wr_index;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    int start_cnt = 0;
    int strobes[$];
    int exp_strobes[$];
    logic [7:0] mregs [NREG];
    int mptr;

    i2c_target_if bus();

    assign line       = m_sda & ~bus.sda_oe;
    assign bus.sda_in = line;

    i2c_target #(.DEV_ADDR(DEV), .NREG(NREG)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .bus       (bus),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strobes.push_back(int'(wr_index));
        if (bus.sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
        if (dut.start_cond) start_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*NREG-1:0] model_flat();
        logic [8*NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[8*i +: 8] = mregs[i];
        return v;
    endfunction

    task automatic hold();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; hold();
        bus.scl = 1'b1; hold();
        m_sda = 1'b0; hold();
        bus.scl = 1'b0; repeat (2) @(negedge clk);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; hold();
        bus.scl = 1'b1; hold();
        m_sda = 1'b1; hold();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; hold();
        bus.scl = 1'b1; hold();
        bus.scl = 1'b0; repeat (2) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; hold();
        bus.scl = 1'b1; hold();
        acked = ~line;
        bus.scl = 1'b0; repeat (2) @(negedge clk);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_sda = 1'b1; hold();
            bus.scl = 1'b1; hold();
            b = {b[6:0], line};
            bus.scl = 1'b0; repeat (2) @(negedge clk);
        end
        send_bit(nack);
        m_sda = 1'b1;
    endtask

    task automatic m_write(input logic [7:0] p, input logic [31:0] data, input int n);
        logic acked;
        logic [7:0] b;
        int base;
        base = strobes.size();
        exp_strobes.delete();
        i2c_start();
        write_byte({DEV, 1'b0}, acked); chk("wr_addr_ack", acked, 1);
        chk("wr_busy", busy, 1);
        write_byte(p, acked); chk("wr_ptr_ack", acked, 1);
        mptr = int'(p) % NREG;
        for (int i = 0; i < n; i++) begin
            b = data[8*i +: 8];
            write_byte(b, acked); chk("wr_data_ack", acked, 1);
            hold(); chk("wr_ack_release", bus.sda_oe, 0);
            mregs[mptr] = b;
            exp_strobes.push_back(mptr);
            mptr = (mptr + 1) % NREG;
        end
        i2c_stop();
        chk("wr_busy_stop", busy, 0);
        chk("wr_strobe_count", strobes.size() - base, exp_strobes.size());
        for (int i = 0; i < exp_strobes.size() && base + i < strobes.size(); i++)
            chk("wr_index", strobes[base + i], exp_strobes[i]);
        chk("wr_regs", regs_out, model_flat());
    endtask

    task automatic m_read(input logic [7:0] p, input int n);
        logic acked;
        logic [7:0] b;
        i2c_start();
        write_byte({DEV, 1'b0}, acked); chk("rd_addr_w_ack", acked, 1);
        write_byte(p, acked); chk("rd_ptr_ack", acked, 1);
        mptr = int'(p) % NREG;
        i2c_start();
        write_byte({DEV, 1'b1}, acked); chk("rd_addr_r_ack", acked, 1);
        chk("rd_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            chk("rd_data", b, mregs[mptr]);
            if (i != n - 1) mptr = (mptr + 1) % NREG;
        end
        hold(); chk("rd_nack_release", bus.sda_oe, 0);
        i2c_stop();
        chk("rd_busy_stop", busy, 0);
    endtask

    initial begin
        logic acked;
        logic got;
        int oe0, busy0, st0;
        logic [7:0] dbyte;

        res_n = 1'b0; bus.scl = 1'b1; m_sda = 1'b1;
        for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_index", wr_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_regs", regs_out, 0);
        res_n = 1'b1;
        repeat (5) @(negedge clk);

        // basic write: pointer 1, A5 then 5A
        m_write(8'h01, 32'h0000_5AA5, 2);
        chk("w_reg1", regs_out[15:8], 8'hA5);
        chk("w_reg2", regs_out[23:16], 8'h5A);

        // read with wrap from reg3 to reg0
        mregs[3] = 8'hC3; mregs[0] = 8'h3C;
        m_write(8'h03, 32'h0000_3CC3, 2);
        m_read(8'h03, 2);

        // address mismatch
        oe0 = oe_cnt; busy0 = busy_cnt;
        i2c_start();
        write_byte(8'h90, acked); chk("mm_addr_nack", acked, 0);
        write_byte(8'h00, acked); chk("mm_data_nack", acked, 0);
        i2c_stop();
        chk("mm_oe_never", oe_cnt - oe0, 0);
        chk("mm_busy_never", busy_cnt - busy0, 0);
        chk("mm_regs", regs_out, model_flat());

        // randomized traffic
        for (int t = 0; t < 6; t++) begin
            m_write(8'($urandom_range(0, 255)), $urandom(), $urandom_range(1, 4));
            m_read(8'($urandom_range(0, 255)), $urandom_range(1, 5));
        end

        // reset while the target is driving a data ACK
        i2c_start();
        write_byte({DEV, 1'b0}, acked);
        write_byte(8'h02, acked);
        dbyte = 8'($urandom_range(0, 255));
        for (int i = 7; i >= 0; i--) send_bit(dbyte[i]);
        m_sda = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = bus.sda_oe;
        end
        chk("rst_ack_seen", got, 1);
        #2 res_n = 1'b0;
        #1 chk("rst_mid_oe", bus.sda_oe, 0);
        chk("rst_mid_regs", regs_out, 0);
        chk("rst_mid_busy", busy, 0);
        for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
        @(negedge clk);
        res_n = 1'b1;
        repeat (3) @(negedge clk);
        i2c_stop();
        m_write(8'h02, 32'h0000_9966, 2);
        m_read(8'h02, 3);

        // one-clock SDA glitch while SCL high in IDLE
        bus.scl = 1'b1; m_sda = 1'b1;
        repeat (10) @(negedge clk);
        st0 = start_cnt;
        m_sda = 1'b0;
        @(negedge clk);
        m_sda = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_start", start_cnt - st0, EXP_GLITCH_STARTS);
        chk("glitch_busy", busy, 0);
        m_write(8'h00, $urandom(), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42, meaning the 7-bit I2C device address this block answers to.
REQ-002 SHALL have parameter NREG, default 4, meaning the number of 8-bit registers (power of two, 2..16).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, system clock) and res_n (input, 1, asynchronous active-low reset).
REQ-004 scl  input  1  bus clock from master; no clock stretching.
REQ-005 sda_in  input  1  bus data as sampled from the pad.
REQ-006 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 regs_out  output  8*NREG  flat register file; reg[i] = regs_out[8i+7:8i].
REQ-008 wr_strobe  output  1  one-cycle pulse when a data byte is written into a register.
REQ-009 wr_index  output  4  register index of the write, valid with wr_strobe.
REQ-010 busy  output  1  high from an address-matched START until the next STOP.

Function
REQ-011 scl and sda_in SHALL pass through 2-flop synchronizers; edge and condition detection SHALL use synchronized values only.
REQ-012 Conditions:
- START = sda falling while scl high.
- STOP = sda rising while scl high.
- Data SHALL be sampled on scl rising edge, MSB first.
REQ-013 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-014 START (including repeated START) from any state SHALL go to ADDR and clear the bit counter.
REQ-015 STOP from any state SHALL go to IDLE and release sda_oe.
REQ-016 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR go to ADDR_ACK, otherwise go to IDLE with no ACK.
REQ-017 ACK drive: sda_oe SHALL assert on the scl falling edge after bit 8 and release on the scl falling edge after the 9th clock.
REQ-018 After ADDR_ACK: R/W=0 goes to PTR; R/W=1 goes to RDATA.
REQ-019 PTR: the received byte modulo NREG SHALL load the pointer, then go to PTR_ACK, then WDATA.
REQ-020 WDATA: each byte SHALL be written to reg[ptr], with wr_strobe pulsed in the cycle the 8th bit is sampled; then WDATA_ACK (ACK driven), then the pointer increments and wraps NREG-1 to 0.
REQ-021 RDATA: reg[ptr] SHALL be shifted out.
- Bit 7 is driven immediately after the ADDR_ACK or RDATA_ACK release edge; subsequent bits change on scl falling edges.
- sda_oe = ~bit.
REQ-022 RDATA_ACK: sda_oe is released and the master's bit is sampled on the 9th scl rise.
- ACK (0): pointer increments with wrap, return to RDATA.
- NACK (1): go to IDLE.
REQ-023 A write to reg[i] and a simultaneous read of reg[i] SHALL NOT occur; a read always uses the register value at the start of the byte.
REQ-024 busy SHALL rise in the cycle ADDR_ACK is entered and fall on STOP or on an address mismatch.

Reset
REQ-025 On res_n low, all of the following SHALL hold asynchronously:
- state=IDLE, sda_oe=0, wr_strobe=0, wr_index=0, busy=0;
- pointer=0, all registers=8'h00, synchronizers=1 (idle bus).
REQ-026 Reset asserted mid-transfer SHALL release SDA immediately; after release the block waits for a new START.

Configuration
REQ-027 With macro I2C_TARGET_GLITCH_FILTER_EN defined:
- synchronized scl/sda SHALL pass a 3-sample majority filter (2 added cycles of latency, pulses of 1 clk rejected).
- Without the macro, no filter exists and latency is the synchronizer only.

Verification
REQ-028 Write: START, 0x84, 0x01, 0xA5, 0x5A, STOP -> three ACKs after the address; reg1=0xA5, reg2=0x5A; wr_strobe twice with wr_index 1 then 2.
REQ-029 Read with wrap: write pointer 0x03, repeated START, 0x85, read 2 bytes (ACK, then NACK) -> bytes reg3 then reg0; IDLE after the NACK; sda_oe=0.
REQ-030 Mismatch: START, 0x90, 0x00, STOP -> sda_oe never asserted, busy stays 0, registers unchanged.
REQ-031 Reset mid-ACK: assert res_n low while sda_oe=1 -> sda_oe=0 in the same cycle; registers=0; next valid transaction completes normally.
REQ-032 Filter: with I2C_TARGET_GLITCH_FILTER_EN, inject a 1-clk sda low pulse while scl is high in IDLE -> no START is detected; without the macro, a START is detected.
